// File: rtl/fpu_pipe.sv
// fpu_pipe: three-stage pipelined add/sub/compare/mov FPU with valid/ready.
// Define FPU_PIPE_RNE_EN for round-to-nearest-even; default truncates.
module fpu_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             fpu_op,
    input  logic [EXP_W+MAN_W:0]   f1,
    input  logic [EXP_W+MAN_W:0]   f2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fpu_out,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 4;
    localparam int EMAXI = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [EXP_W-1:0] EMAXM1 = EMAX - 1'b1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPU_PIPE_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_EQ  = 4'd4;
    localparam logic [3:0] OP_LE  = 4'd5;
    localparam logic [3:0] OP_LT  = 4'd6;
    localparam logic [3:0] OP_GE  = 4'd7;
    localparam logic [3:0] OP_GT  = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    // leading-zero count of an aligned significand
    function automatic int lzc(input logic [SW-1:0] v);
        int n;
        n = SW;
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = SW - 1 - i;
        end
        return n;
    endfunction

    logic w_adv;

    // S1: unpack, classify, compare, align
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_sa, w_sb;
    logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [W-2:0]     w_maga, w_magb, w_big, w_sml;
    logic             w_aneg, w_bneg, w_lt, w_eq;
    logic             w_swap, w_sbig, w_ssml;
    logic [EXP_W-1:0] w_diff;
    logic [31:0]      w_diff32, w_sh;
    logic [SW-1:0]    w_big_sig, w_sml_ext, w_sml_sh, w_mask, w_sml_al;
    logic             w_stk;
    logic             w_byp1;
    logic [W-1:0]     w_res1;
    logic [3:0]       w_flg1;

    logic                 r_s1_vld, r_s1_byp, r_s1_sgn, r_s1_sub;
    logic [TAG_W-1:0]     r_s1_tag;
    logic [W-1:0]         r_s1_res;
    logic [3:0]           r_s1_flg;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [SW-1:0]        r_s1_big, r_s1_sml;

    // S2: magnitude add/subtract
    logic [SW:0]          w_sum;
    logic                 w_s2_sgn;

    logic                 r_s2_vld, r_s2_byp, r_s2_sgn;
    logic [TAG_W-1:0]     r_s2_tag;
    logic [W-1:0]         r_s2_res;
    logic [3:0]           r_s2_flg;
    logic [EXP_W-1:0]     r_s2_exp;
    logic [SW:0]          r_s2_sum;

    // S3: normalise, round, range check
    int                   w_lz, w_e;
    logic [SW-1:0]        w_norm;
    logic [MAN_W-1:0]     w_m;
    logic                 w_g, w_r, w_s, w_inc;
    logic [MAN_W+1:0]     w_rsig;
    logic [W-1:0]         w_res3;
    logic [3:0]           w_flg3;

    logic                 r_out_vld;
    logic [W-1:0]         r_out;
    logic [TAG_W-1:0]     r_out_tag;
    logic [3:0]           r_out_flg;

    assign w_adv     = !r_out_vld || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_vld;
    assign fpu_out   = r_out;
    assign out_tag   = r_out_tag;
    assign flags     = r_out_flg;

    assign w_ea = f1[W-2 -: EXP_W];
    assign w_eb = f2[W-2 -: EXP_W];
    assign w_ma = f1[MAN_W-1:0];
    assign w_mb = f2[MAN_W-1:0];
    assign w_sa = f1[W-1];
    assign w_sb = f2[W-1] ^ (fpu_op == OP_SUB);
    assign w_za = (w_ea == '0);
    assign w_zb = (w_eb == '0);
    assign w_ia = (w_ea == EMAX) && (w_ma == '0);
    assign w_ib = (w_eb == EMAX) && (w_mb == '0);
    assign w_na = (w_ea == EMAX) && (w_ma != '0);
    assign w_nb = (w_eb == EMAX) && (w_mb != '0);

    assign w_maga = w_za ? '0 : f1[W-2:0];
    assign w_magb = w_zb ? '0 : f2[W-2:0];
    assign w_aneg = f1[W-1] & ~w_za;
    assign w_bneg = f2[W-1] & ~w_zb;
    assign w_eq   = (w_maga == w_magb) && (w_aneg == w_bneg);

    // sign-magnitude ordering with both zeros equal
    always_comb begin
        w_lt = 1'b0;
        if (w_aneg != w_bneg) w_lt = w_aneg;
        else if (w_aneg)      w_lt = (w_maga > w_magb);
        else                  w_lt = (w_maga < w_magb);
    end

    assign w_swap = (w_magb > w_maga);
    assign w_big  = w_swap ? w_magb : w_maga;
    assign w_sml  = w_swap ? w_maga : w_magb;
    assign w_sbig = w_swap ? w_sb : w_sa;
    assign w_ssml = w_swap ? w_sa : w_sb;

    assign w_big_sig = {w_big[W-2 -: EXP_W] != '0, w_big[MAN_W-1:0], 3'b000};
    assign w_sml_ext = {w_sml[W-2 -: EXP_W] != '0, w_sml[MAN_W-1:0], 3'b000};
    assign w_diff    = w_big[W-2 -: EXP_W] - w_sml[W-2 -: EXP_W];
    assign w_diff32  = {{(32-EXP_W){1'b0}}, w_diff};
    assign w_sh      = (w_diff32 > 32'(SW-1)) ? 32'(SW-1) : w_diff32;
    assign w_sml_sh  = w_sml_ext >> w_sh;
    assign w_mask    = ~({SW{1'b1}} << w_sh);
    assign w_stk     = |(w_sml_ext & w_mask);
    assign w_sml_al  = {w_sml_sh[SW-1:1], w_sml_sh[0] | w_stk};

    // results fully decided in S1: specials, compares, mov, illegal
    always_comb begin
        w_byp1 = 1'b1;
        w_res1 = '0;
        w_flg1 = '0;
        unique case (fpu_op)
            OP_ADD, OP_SUB: begin
                if (w_na || w_nb) begin
                    w_res1 = QNAN;
                end else if (w_ia && w_ib && (w_sa != w_sb)) begin
                    w_res1    = QNAN;
                    w_flg1[3] = 1'b1;
                end else if (w_ia) begin
                    w_res1 = {w_sa, EMAX, {MAN_W{1'b0}}};
                end else if (w_ib) begin
                    w_res1 = {w_sb, EMAX, {MAN_W{1'b0}}};
                end else begin
                    w_byp1 = 1'b0;
                end
            end
            OP_EQ, OP_LE, OP_LT, OP_GE, OP_GT: begin
                if (w_na || w_nb) begin
                    w_flg1[3] = 1'b1;
                end else begin
                    unique case (fpu_op)
                        OP_EQ:   w_res1[0] = w_eq;
                        OP_LE:   w_res1[0] = w_lt | w_eq;
                        OP_LT:   w_res1[0] = w_lt;
                        OP_GE:   w_res1[0] = ~w_lt;
                        default: w_res1[0] = ~(w_lt | w_eq);
                    endcase
                end
            end
            OP_MOV: begin
                w_res1 = f1;
            end
            default: begin
                w_flg1[0] = 1'b1;
            end
        endcase
    end

    // S1 register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_byp <= 1'b0;
            r_s1_sgn <= 1'b0;
            r_s1_sub <= 1'b0;
            r_s1_tag <= '0;
            r_s1_res <= '0;
            r_s1_flg <= '0;
            r_s1_exp <= '0;
            r_s1_big <= '0;
            r_s1_sml <= '0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            r_s1_byp <= w_byp1;
            r_s1_sgn <= w_sbig;
            r_s1_sub <= w_sbig ^ w_ssml;
            r_s1_tag <= in_tag;
            r_s1_res <= w_res1;
            r_s1_flg <= w_flg1;
            r_s1_exp <= w_big[W-2 -: EXP_W];
            r_s1_big <= w_big_sig;
            r_s1_sml <= w_sml_al;
        end
    end

    assign w_sum = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_sml})
                            : ({1'b0, r_s1_big} + {1'b0, r_s1_sml});
    assign w_s2_sgn = (r_s1_sub && (w_sum == '0)) ? 1'b0 : r_s1_sgn;

    // S2 register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_byp <= 1'b0;
            r_s2_sgn <= 1'b0;
            r_s2_tag <= '0;
            r_s2_res <= '0;
            r_s2_flg <= '0;
            r_s2_exp <= '0;
            r_s2_sum <= '0;
        end else if (w_adv) begin
            r_s2_vld <= r_s1_vld;
            r_s2_byp <= r_s1_byp;
            r_s2_sgn <= w_s2_sgn;
            r_s2_tag <= r_s1_tag;
            r_s2_res <= r_s1_res;
            r_s2_flg <= r_s1_flg;
            r_s2_exp <= r_s1_exp;
            r_s2_sum <= w_sum;
        end
    end

    // normalise, round and range-check the S2 sum
    always_comb begin
        w_lz   = lzc(r_s2_sum[SW-1:0]);
        w_e    = int'(r_s2_exp);
        w_norm = '0;
        if (r_s2_sum[SW]) begin
            w_norm = {r_s2_sum[SW:2], r_s2_sum[1] | r_s2_sum[0]};
            w_e    = w_e + 1;
        end else begin
            w_norm = r_s2_sum[SW-1:0] << w_lz;
            w_e    = w_e - w_lz;
        end
        w_m    = w_norm[SW-2:3];
        w_g    = w_norm[2];
        w_r    = w_norm[1];
        w_s    = w_norm[0];
        w_inc  = RNE & w_g & (w_r | w_s | w_m[0]);
        w_rsig = {1'b0, w_norm[SW-1], w_m} + {{(MAN_W+1){1'b0}}, w_inc};
        if (w_rsig[MAN_W+1]) begin
            w_m = w_rsig[MAN_W:1];
            w_e = w_e + 1;
        end else begin
            w_m = w_rsig[MAN_W-1:0];
        end
        w_res3 = '0;
        w_flg3 = '0;
        if (r_s2_byp) begin
            w_res3 = r_s2_res;
            w_flg3 = r_s2_flg;
        end else if (r_s2_sum == '0) begin
            w_res3 = {r_s2_sgn, {(W-1){1'b0}}};
        end else if (w_e >= EMAXI) begin
            w_flg3[2] = 1'b1;
            w_res3 = RNE ? {r_s2_sgn, EMAX, {MAN_W{1'b0}}}
                         : {r_s2_sgn, EMAXM1, {MAN_W{1'b1}}};
        end else if (w_e <= 0) begin
            w_flg3[1] = 1'b1;
            w_res3 = {r_s2_sgn, {(W-1){1'b0}}};
        end else begin
            w_res3 = {r_s2_sgn, w_e[EXP_W-1:0], w_m};
        end
    end

    // output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_out_tag <= '0;
            r_out_flg <= '0;
        end else if (w_adv) begin
            r_out_vld <= r_s2_vld;
            r_out     <= r_s2_vld ? w_res3 : '0;
            r_out_tag <= r_s2_vld ? r_s2_tag : '0;
            r_out_flg <= r_s2_vld ? w_flg3 : '0;
        end
    end

endmodule

// File: tb/tb_fpu_pipe.sv
// tb_fpu_pipe: directed vectors with a queue scoreboard for fpu_pipe.
// Expected rounding results follow FPU_PIPE_RNE_EN when it is defined.
module tb_fpu_pipe;

`ifdef FPU_PIPE_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  fpu_op = '0;
    logic [31:0] f1 = '0;
    logic [31:0] f2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fpu_out;
    logic [4:0]  out_tag;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rx = 0;
    int   acc_n = 0;
    bit   lat_mode = 1'b1;

    fpu_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fpu_op    (fpu_op),
        .f1        (f1),
        .f2        (f2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fpu_out   (fpu_out),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // offer one operation; push its expectation when it is accepted
    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        int   n;
        fpu_op   = op;
        f1       = a;
        f2       = b;
        in_tag   = tag;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag %0d got stalled want accepted", tag);
        end else begin
            e.res = er;
            e.flg = ef;
            e.tag = tag;
            e.acc = cyc + 1;
            e.lat = lat_mode;
            q.push_back(e);
            acc_n++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    // monitor: compare every presented result with the queue head
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got %h tag %0d want none",
                             fpu_out, out_tag);
                    if (out_ready) rx++;
                end else if (!out_ready) begin
                    e = q[0];
                    check($sformatf("stall_data_t%0d", e.tag), fpu_out, e.res);
                end else begin
                    e = q.pop_front();
                    rx++;
                    check($sformatf("data_t%0d", e.tag), fpu_out, e.res);
                    check($sformatf("flags_t%0d", e.tag), {28'd0, flags}, {28'd0, e.flg});
                    check($sformatf("tag_t%0d", e.tag), {27'd0, out_tag}, {27'd0, e.tag});
                    if (e.lat)
                        check($sformatf("latency_t%0d", e.tag), cyc - e.acc, 2);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rx0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_fpu_out", fpu_out, 0);
        check("rst_out_tag", {27'd0, out_tag}, 0);
        check("rst_flags", {28'd0, flags}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);

        send(4'd2, 32'h3F800000, 32'h40000000, 5'd1,  32'h40400000, 4'b0000);
        send(4'd3, 32'h3F800000, 32'h3F800000, 5'd2,  32'h00000000, 4'b0000);
        send(4'd4, 32'h80000000, 32'h00000000, 5'd3,  32'h00000001, 4'b0000);
        send(4'd6, 32'h7FC00000, 32'h3F800000, 5'd4,  32'h00000000, 4'b1000);
        send(4'd2, 32'h3F800000, 32'h33C00000, 5'd5,
             RNE ? 32'h3F800001 : 32'h3F800000, 4'b0000);
        send(4'd2, 32'h3F800000, 32'h33800000, 5'd6,  32'h3F800000, 4'b0000);
        send(4'd2, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd7,
             RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'b0100);
        send(4'd2, 32'h7F800000, 32'hFF800000, 5'd8,  32'h7FC00000, 4'b1000);
        send(4'd15, 32'h3F800000, 32'h40000000, 5'd9, 32'h00000000, 4'b0001);
        send(4'd9, 32'h7FC00001, 32'h3F800000, 5'd10, 32'h7FC00001, 4'b0000);
        send(4'd5, 32'h3F800000, 32'h40000000, 5'd11, 32'h00000001, 4'b0000);
        send(4'd8, 32'hBF800000, 32'h3F800000, 5'd12, 32'h00000000, 4'b0000);
        send(4'd7, 32'h40000000, 32'h40000000, 5'd13, 32'h00000001, 4'b0000);
        send(4'd2, 32'h7FC00001, 32'h3F800000, 5'd14, 32'h7FC00000, 4'b0000);
        send(4'd2, 32'h7F800000, 32'h3F800000, 5'd15, 32'h7F800000, 4'b0000);
        send(4'd3, 32'h00800001, 32'h00800000, 5'd16, 32'h00000000, 4'b0010);
        send(4'd2, 32'h00000001, 32'h3F800000, 5'd17, 32'h3F800000, 4'b0000);
        send(4'd3, 32'h3F800000, 32'h40400000, 5'd18, 32'hC0000000, 4'b0000);
        send(4'd3, 32'h3F800000, 32'h7F800000, 5'd19, 32'hFF800000, 4'b0000);
        send(4'd0, 32'h3F800000, 32'h3F800000, 5'd20, 32'h00000000, 4'b0001);
        drain();

        // backpressure: five offered, only three fit while stalled
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        acc_n     = 0;
        rx0       = rx;
        fork
            begin
                send(4'd2, 32'h3F800000, 32'h40000000, 5'd21, 32'h40400000, 4'b0000);
                send(4'd2, 32'h40000000, 32'h40000000, 5'd22, 32'h40800000, 4'b0000);
                send(4'd9, 32'hC0A00000, 32'h00000000, 5'd23, 32'hC0A00000, 4'b0000);
                send(4'd4, 32'h40000000, 32'h40000000, 5'd24, 32'h00000001, 4'b0000);
                send(4'd3, 32'h40400000, 32'h3F800000, 5'd25, 32'h40000000, 4'b0000);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_accepted", acc_n, 3);
                check("bp_in_ready", {31'd0, in_ready}, 0);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_total_accepted", acc_n, 5);
        check("bp_total_results", rx - rx0, 5);

        // asynchronous reset with operations in flight
        lat_mode  = 1'b1;
        out_ready = 1'b0;
        send(4'd2, 32'h3F800000, 32'h3F800000, 5'd26, 32'h40000000, 4'b0000);
        send(4'd2, 32'h40000000, 32'h40000000, 5'd27, 32'h40800000, 4'b0000);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_valid", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_fpu_out", fpu_out, 0);
        check("arst_out_tag", {27'd0, out_tag}, 0);
        check("arst_flags", {28'd0, flags}, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        rx0       = rx;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 1);
        repeat (8) @(posedge clk);
        #2;
        check("no_stale_results", rx - rx0, 0);

        send(4'hF, 32'h3F800000, 32'h40000000, 5'd28, 32'h00000000, 4'b0001);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
